// File: rtl/usb_wire_pkg.sv
// usb_wire_pkg: shared definitions for the multi-agent USB wire model.
//   line_state_e    encoding of the resolved line condition
//   CONT_COUNT_MAX  saturation value of the contention cycle counter
//   sat_inc8()      saturating 8-bit increment
package usb_wire_pkg;

  typedef enum logic [1:0] {
    LINE_DISCONNECTED = 2'd0,
    LINE_IDLE         = 2'd1,
    LINE_ACTIVE       = 2'd2,
    LINE_SE0_RESET    = 2'd3
  } line_state_e;

  localparam logic [7:0] CONT_COUNT_MAX = 8'd255;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == CONT_COUNT_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/usb_wire_drv_enc.sv
// usb_wire_drv_enc: classifies the per-agent drive enables.
//   ctrl_i   in  NUM_AGENTS  drive enable per agent
//   none_o   out 1           no agent driving
//   one_o    out 1           exactly one agent driving
//   many_o   out 1           two or more agents driving
//   index_o  out OWNER_W     index of the lowest driving agent (meaningful when one_o)
module usb_wire_drv_enc #(
  parameter int NUM_AGENTS = 2,
  parameter int OWNER_W    = $clog2(NUM_AGENTS)
) (
  input  logic [NUM_AGENTS-1:0] ctrl_i,
  output logic                  none_o,
  output logic                  one_o,
  output logic                  many_o,
  output logic [OWNER_W-1:0]    index_o
);

  // Driver count saturates at 2: only "0, 1, 2 or more" matters.
  logic [1:0] seen;

  always_comb begin
    seen    = 2'd0;
    index_o = '0;
    for (int i = 0; i < NUM_AGENTS; i++) begin
      if (ctrl_i[i]) begin
        if (seen == 2'd0) index_o = OWNER_W'(i);
        if (seen != 2'd2) seen = seen + 2'd1;
      end
    end
    none_o = (seen == 2'd0);
    one_o  = (seen == 2'd1);
    many_o = (seen == 2'd2);
  end

endmodule

// File: rtl/usb_wire_resolver.sv
// usb_wire_resolver: resolves NUM_AGENTS USB wire drivers plus D+/D- pull
// configuration into one registered {VP,VM} line value, tracking ownership,
// contention and bus reset (long driven SE0).
//   clk_i, rst_i          clock, asynchronous active-high reset
//   agentCtrlOut_i        per-agent drive enable
//   agentDataOut_i        per-agent {VP,VM}, agent k at [2k+1:2k]
//   dPlusPullup_i         1 = D+ pulled up
//   dMinusPullup_i        1 = D- pulled up
//   clearStatus_i         clears contention flag and count
//   lineData_o            resolved {VP,VM}
//   lineOwner_o           current / last sole driver
//   ownerValid_o          exactly one agent driving
//   lineState_o           line_state_e encoding
//   contention_o          sticky multi-driver flag
//   contentionCount_o     contention cycles, saturating at 255
//   busResetDet_o         one-cycle pulse when a bus reset is recognised
module usb_wire_resolver
  import usb_wire_pkg::*;
#(
  parameter int NUM_AGENTS       = 2,
  parameter int RESET_SE0_CYCLES = 125,
  parameter int OWNER_W          = $clog2(NUM_AGENTS)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_AGENTS-1:0]   agentCtrlOut_i,
  input  logic [2*NUM_AGENTS-1:0] agentDataOut_i,
  input  logic                    dPlusPullup_i,
  input  logic                    dMinusPullup_i,
  input  logic                    clearStatus_i,
  output logic [1:0]              lineData_o,
  output logic [OWNER_W-1:0]      lineOwner_o,
  output logic                    ownerValid_o,
  output logic [1:0]              lineState_o,
  output logic                    contention_o,
  output logic [7:0]              contentionCount_o,
  output logic                    busResetDet_o
);

  localparam int SE0_W = $clog2(RESET_SE0_CYCLES + 1);
  localparam logic [SE0_W-1:0] SE0_MAX = SE0_W'(RESET_SE0_CYCLES);

  logic [1:0] agent_data [NUM_AGENTS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_AGENTS; gi++) begin : g_unpack
      assign agent_data[gi] = agentDataOut_i[2*gi+1:2*gi];
    end
  endgenerate

  logic               drv_none;
  logic               drv_one;
  logic               drv_many;
  logic [OWNER_W-1:0] drv_index;

  usb_wire_drv_enc #(
    .NUM_AGENTS (NUM_AGENTS),
    .OWNER_W    (OWNER_W)
  ) u_drv_enc (
    .ctrl_i  (agentCtrlOut_i),
    .none_o  (drv_none),
    .one_o   (drv_one),
    .many_o  (drv_many),
    .index_o (drv_index)
  );

  logic [1:0]         line_q, line_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic               owner_valid_q, owner_valid_d;
  line_state_e        state_q, state_d;
  logic               cont_q, cont_d;
  logic [7:0]         cont_cnt_q, cont_cnt_d;
  logic               bus_reset_q, bus_reset_d;
  logic [SE0_W-1:0]   se0_cnt_q, se0_cnt_d;

  logic [1:0] sel_data;
  logic       se0_drive;

  assign sel_data  = agent_data[drv_index];
  assign se0_drive = drv_one && (sel_data == 2'b00);

  always_comb begin
    line_d        = 2'b00;
    owner_d       = owner_q;
    owner_valid_d = 1'b0;
    state_d       = LINE_ACTIVE;
    se0_cnt_d     = '0;
    bus_reset_d   = 1'b0;

    // SE0 run length. owner_q still names the previous sole driver here, so
    // a handover to a different agent driving SE0 restarts the run at 1.
    if (se0_drive) begin
      if (se0_cnt_q != '0 && drv_index != owner_q) begin
        se0_cnt_d = SE0_W'(1);
      end else if (se0_cnt_q != SE0_MAX) begin
        se0_cnt_d = se0_cnt_q + SE0_W'(1);
      end else begin
        se0_cnt_d = se0_cnt_q;
      end
    end

    if (drv_none) begin
      line_d  = {dPlusPullup_i, dMinusPullup_i};
      state_d = (dPlusPullup_i || dMinusPullup_i) ? LINE_IDLE : LINE_DISCONNECTED;
    end else if (drv_one) begin
      line_d        = sel_data;
      owner_d       = drv_index;
      owner_valid_d = 1'b1;
      if (se0_drive && se0_cnt_d == SE0_MAX) begin
        state_d     = LINE_SE0_RESET;
        bus_reset_d = (se0_cnt_q != SE0_MAX);
      end
    end
    // drv_many: line forced low, ACTIVE, owner held (defaults above).

    // A contention event in the same cycle as a clear takes precedence.
    if (clearStatus_i) begin
      cont_d     = drv_many;
      cont_cnt_d = drv_many ? 8'd1 : 8'd0;
    end else begin
      cont_d     = cont_q | drv_many;
      cont_cnt_d = drv_many ? sat_inc8(cont_cnt_q) : cont_cnt_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      line_q        <= 2'b00;
      owner_q       <= '0;
      owner_valid_q <= 1'b0;
      state_q       <= LINE_DISCONNECTED;
      cont_q        <= 1'b0;
      cont_cnt_q    <= 8'd0;
      bus_reset_q   <= 1'b0;
      se0_cnt_q     <= '0;
    end else begin
      line_q        <= line_d;
      owner_q       <= owner_d;
      owner_valid_q <= owner_valid_d;
      state_q       <= state_d;
      cont_q        <= cont_d;
      cont_cnt_q    <= cont_cnt_d;
      bus_reset_q   <= bus_reset_d;
      se0_cnt_q     <= se0_cnt_d;
    end
  end

  assign lineData_o        = line_q;
  assign lineOwner_o       = owner_q;
  assign ownerValid_o      = owner_valid_q;
  assign lineState_o       = state_q;
  assign contention_o      = cont_q;
  assign contentionCount_o = cont_cnt_q;
  assign busResetDet_o     = bus_reset_q;

endmodule

// File: tb/tb_usb_wire_resolver.sv
// Bench for usb_wire_resolver: a 2-agent and a 4-agent instance share the
// pull-up/clear inputs; the 2-agent instance sees agents 0..1 of the stimulus.
module tb_usb_wire_resolver;

  localparam int RSE0 = 8;

  typedef struct packed {
    logic [1:0] line;
    logic [3:0] owner;
    logic       ov;
    logic [1:0] st;
    logic       cont;
    logic [7:0] cnt;
    logic       pulse;
    logic [7:0] se0;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ctrl_s = '0;
  logic [7:0] data_s = '0;
  logic       dpp = 1'b0;
  logic       dmp = 1'b0;
  logic       clr = 1'b0;

  logic [1:0] line2, st2, line4, st4;
  logic       owner2, ov2, cont2, pulse2, ov4, cont4, pulse4;
  logic [1:0] owner4;
  logic [7:0] cnt2, cnt4;

  always #5 clk = ~clk;

  usb_wire_resolver #(.NUM_AGENTS(2), .RESET_SE0_CYCLES(RSE0)) u_dut2 (
    .clk_i(clk), .rst_i(rst),
    .agentCtrlOut_i(ctrl_s[1:0]), .agentDataOut_i(data_s[3:0]),
    .dPlusPullup_i(dpp), .dMinusPullup_i(dmp), .clearStatus_i(clr),
    .lineData_o(line2), .lineOwner_o(owner2), .ownerValid_o(ov2),
    .lineState_o(st2), .contention_o(cont2), .contentionCount_o(cnt2),
    .busResetDet_o(pulse2)
  );

  usb_wire_resolver #(.NUM_AGENTS(4), .RESET_SE0_CYCLES(RSE0)) u_dut4 (
    .clk_i(clk), .rst_i(rst),
    .agentCtrlOut_i(ctrl_s), .agentDataOut_i(data_s),
    .dPlusPullup_i(dpp), .dMinusPullup_i(dmp), .clearStatus_i(clr),
    .lineData_o(line4), .lineOwner_o(owner4), .ownerValid_o(ov4),
    .lineState_o(st4), .contention_o(cont4), .contentionCount_o(cnt4),
    .busResetDet_o(pulse4)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_step   = 0;
  exp_t m2 = '0;
  exp_t m4 = '0;
  exp_t sb[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cmp_all(input string who, input exp_t e, input logic [1:0] line,
                         input logic [3:0] owner, input logic ov, input logic [1:0] st,
                         input logic cont, input logic [7:0] cnt, input logic pulse);
    check_eq({who, ".line"},  32'(line),  32'(e.line));
    check_eq({who, ".owner"}, 32'(owner), 32'(e.owner));
    check_eq({who, ".ov"},    32'(ov),    32'(e.ov));
    check_eq({who, ".state"}, 32'(st),    32'(e.st));
    check_eq({who, ".cont"},  32'(cont),  32'(e.cont));
    check_eq({who, ".count"}, 32'(cnt),   32'(e.cnt));
    check_eq({who, ".pulse"}, 32'(pulse), 32'(e.pulse));
  endtask

  task automatic cmp_both(input exp_t e2, input exp_t e4);
    cmp_all("a2", e2, line2, {3'b000, owner2}, ov2, st2, cont2, cnt2, pulse2);
    cmp_all("a4", e4, line4, {2'b00, owner4}, ov4, st4, cont4, cnt4, pulse4);
  endtask

  // Reference behaviour of one resolver over one clock.
  function automatic exp_t model_next(input exp_t s, input int na, input logic [3:0] ctrl,
                                      input logic [7:0] data, input logic pp, input logic pm,
                                      input logic c);
    exp_t       r = s;
    int         n = 0;
    int         idx = 0;
    logic [1:0] d;
    logic [7:0] se0_new = 8'd0;
    for (int i = 0; i < na; i++) begin
      if (ctrl[i]) begin
        if (n == 0) idx = i;
        n++;
      end
    end
    r.pulse = 1'b0;
    if (n == 0) begin
      r.line = {pp, pm};
      r.ov   = 1'b0;
      r.st   = (pp || pm) ? 2'd1 : 2'd0;
    end else if (n == 1) begin
      d       = data[2*idx +: 2];
      r.line  = d;
      r.owner = idx[3:0];
      r.ov    = 1'b1;
      r.st    = 2'd2;
      if (d == 2'b00) begin
        if (s.se0 != 0 && idx[3:0] != s.owner) se0_new = 8'd1;
        else se0_new = (s.se0 < RSE0) ? s.se0 + 8'd1 : 8'(RSE0);
        if (se0_new == RSE0) begin
          r.st    = 2'd3;
          r.pulse = (s.se0 != RSE0);
        end
      end
    end else begin
      r.line = 2'b00;
      r.ov   = 1'b0;
      r.st   = 2'd2;
    end
    if (c) begin
      r.cont = (n >= 2);
      r.cnt  = (n >= 2) ? 8'd1 : 8'd0;
    end else if (n >= 2) begin
      r.cont = 1'b1;
      r.cnt  = (s.cnt == 8'd255) ? 8'd255 : s.cnt + 8'd1;
    end
    r.se0 = se0_new;
    return r;
  endfunction

  task automatic step(input logic [3:0] ctrl, input logic [7:0] data,
                      input logic pp, input logic pm, input logic c);
    exp_t e2, e4;
    ctrl_s = ctrl; data_s = data; dpp = pp; dmp = pm; clr = c;
    m2 = model_next(m2, 2, ctrl, data, pp, pm, c);
    m4 = model_next(m4, 4, ctrl, data, pp, pm, c);
    sb.push_back(m2);
    sb.push_back(m4);
    @(posedge clk);
    #1;
    e2 = sb.pop_front();
    e4 = sb.pop_front();
    cmp_both(e2, e4);
    n_step++;
    $display("step %0d ctrl=%b data=%h pu=%b%b clr=%b | a2 line=%b st=%0d cnt=%0d rst=%b | a4 line=%b own=%0d st=%0d cnt=%0d rst=%b",
             n_step, ctrl, data, pp, pm, c, line2, st2, cnt2, pulse2, line4, owner4, st4, cnt4, pulse4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    cmp_both('0, '0);
    rst = 1'b0;

    // Idle with D+ pull-up, then fully disconnected
    repeat (2) step(4'b0000, 8'h00, 1'b1, 1'b0, 1'b0);
    step(4'b0000, 8'h00, 1'b0, 1'b0, 1'b0);

    // Agent 1 drives 01 (J/K-ish), owner 1
    repeat (2) step(4'b0010, 8'b0000_0100, 1'b1, 1'b0, 1'b0);

    // Agents 0 and 1 contend for 3 cycles, then clear coinciding with a 4th
    repeat (3) step(4'b0011, 8'b0000_0110, 1'b1, 1'b0, 1'b0);
    step(4'b0011, 8'b0000_0110, 1'b1, 1'b0, 1'b1);
    step(4'b0000, 8'h00, 1'b1, 1'b0, 1'b1);

    // Saturation of the contention counter
    for (int i = 0; i < 300; i++) step(4'b0011, 8'h0f, 1'b1, 1'b0, 1'b0);
    step(4'b0000, 8'h00, 1'b1, 1'b0, 1'b1);

    // SE0 run one short of a bus reset, then released
    repeat (RSE0 - 1) step(4'b0001, 8'h00, 1'b1, 1'b0, 1'b0);
    step(4'b0000, 8'h00, 1'b1, 1'b0, 1'b0);

    // Full SE0 run: single pulse, SE0_RESET held, then back to IDLE
    repeat (RSE0 + 3) step(4'b0001, 8'h00, 1'b1, 1'b0, 1'b0);
    step(4'b0000, 8'h00, 1'b1, 1'b0, 1'b0);

    // Handover with no idle cycle restarts the SE0 run
    repeat (4) step(4'b0001, 8'h00, 1'b1, 1'b0, 1'b0);
    repeat (RSE0 + 1) step(4'b0010, 8'h00, 1'b1, 1'b0, 1'b0);
    step(4'b0001, 8'b0000_0010, 1'b1, 1'b0, 1'b0);

    // Upper agents only visible to the 4-agent instance
    repeat (2) step(4'b1000, 8'b1000_0000, 1'b0, 1'b1, 1'b0);
    repeat (2) step(4'b1100, 8'b1001_0000, 1'b0, 1'b1, 1'b1);
    step(4'b0100, 8'b0001_0000, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset in the middle of an SE0 run
    repeat (5) step(4'b0001, 8'h00, 1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    cmp_both('0, '0);
    m2 = '0;
    m4 = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (RSE0 + 1) step(4'b0001, 8'h00, 1'b1, 1'b0, 1'b0);
    step(4'b0000, 8'h00, 1'b1, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
